// File: rtl/vram_arbiter.sv
// Video RAM arbiter: video owns fixed phases of each 16-clock character cell; the CPU
// gets the remaining phases through a latched req/ack handshake with a wait output.
module vram_arbiter #(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned VID_FIRST = 11,
  parameter int unsigned VID_LAST  = 14
) (
  input  logic              i_clk_pix,
  input  logic              i_nreset,
  input  logic [3:0]        i_vid_phase,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic [7:0]        o_vid_rdata,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_wdata,
  output logic [7:0]        o_cpu_rdata,
  output logic              o_cpu_ack,
  output logic              o_cpu_wait,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [7:0]        o_ram_wdata,
  output logic              o_ram_we,
  input  logic [7:0]        i_ram_q
);

  typedef enum logic [1:0] {StIdle, StPend, StRdData, StAck} state_e;

  state_e              r_state, w_state_d;
  logic                r_we, w_we_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [7:0]          r_wdata, w_wdata_d;
  logic [7:0]          r_rdata, w_rdata_d;
  logic                r_ack, w_ack_d;
  logic                w_in_window;
  logic                w_issue;

  assign w_in_window = (32'(i_vid_phase) >= VID_FIRST) && (32'(i_vid_phase) <= VID_LAST);

  // The CPU only reaches the RAM from PEND, and only outside the video window.
  assign w_issue = (r_state == StPend) && !w_in_window;

  always_comb begin
    w_state_d = r_state;
    w_we_d    = r_we;
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_rdata_d = r_rdata;
    unique case (r_state)
      StIdle: begin
        if (i_cpu_req) begin
          w_we_d    = i_cpu_we;
          w_addr_d  = i_cpu_addr;
          w_wdata_d = i_cpu_wdata;
          w_state_d = StPend;
        end
      end
      StPend: begin
        if (w_issue) begin
          w_state_d = r_we ? StAck : StRdData;
        end
      end
      StRdData: begin
        w_rdata_d = i_ram_q;
        w_state_d = StAck;
      end
      StAck: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    w_ack_d = (w_state_d == StAck);
  end

  always_ff @(posedge i_clk_pix or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state <= StIdle;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_we    <= w_we_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
      r_rdata <= w_rdata_d;
      r_ack   <= w_ack_d;
    end
  end

  always_comb begin
    o_ram_addr  = i_vid_addr;
    o_ram_we    = 1'b0;
    o_ram_wdata = '0;
    if (w_issue) begin
      o_ram_addr  = r_addr;
      o_ram_we    = r_we;
      o_ram_wdata = r_wdata;
    end
  end

  assign o_vid_rdata = i_ram_q;
  assign o_cpu_rdata = r_rdata;
  assign o_cpu_ack   = r_ack;
  assign o_cpu_wait  = i_cpu_req && (r_state != StAck);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a registered single-port RAM model and a
// free-running character phase advanced by the tick task.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        nreset;
  logic [3:0]  vid_phase;
  logic [12:0] vid_addr;
  logic [7:0]  vid_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_wait;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_q;

  int n_checks = 0;
  int n_fail   = 0;
  int wr1_cnt  = 0;

  logic [7:0] mem [0:8191];

  vram_arbiter #(.ADDR_W(13), .VID_FIRST(11), .VID_LAST(14)) dut (
    .i_clk_pix  (clk),
    .i_nreset   (nreset),
    .i_vid_phase(vid_phase),
    .i_vid_addr (vid_addr),
    .o_vid_rdata(vid_rdata),
    .i_cpu_req  (cpu_req),
    .i_cpu_we   (cpu_we),
    .i_cpu_addr (cpu_addr),
    .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata),
    .o_cpu_ack  (cpu_ack),
    .o_cpu_wait (cpu_wait),
    .o_ram_addr (ram_addr),
    .o_ram_wdata(ram_wdata),
    .o_ram_we   (ram_we),
    .i_ram_q    (ram_q)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_we && ram_addr == 13'h0001) wr1_cnt <= wr1_cnt + 1;
    ram_q <= mem[ram_addr];
  end

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'(a >> 5) ^ 8'h5A;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    vid_phase = vid_phase + 4'd1;
    #1;
  endtask

  task automatic wait_phase(input logic [3:0] p);
    for (int i = 0; i < 16 && vid_phase != p; i++) tick();
  endtask

  task automatic cpu_write(input logic [12:0] a, input logic [7:0] d);
    logic got;
    got = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (cpu_ack) got = 1'b1;
    end
    cpu_req = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL write_ack_timeout: ack=%b required=1 addr=%h", cpu_ack, a);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_phase = 4'd0; vid_addr = 13'h0333;
    tick(); tick();
    n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got=%b exp=0", cpu_ack); end
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got=%h exp=00", cpu_rdata); end
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got=%b exp=0", ram_we); end
    n_checks++; if (cpu_wait !== 1'b0) begin n_fail++; $display("FAIL reset_wait: got=%b exp=0", cpu_wait); end
    n_checks++; if (ram_addr !== 13'h0333) begin n_fail++; $display("FAIL reset_ram_addr: got=%h exp=0333", ram_addr); end
    nreset = 1'b1;
    tick();
  endtask

  task automatic test_write_best_case();
    wait_phase(4'd2);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0123; cpu_wdata = 8'hA5;
    #1;
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL wr_ph2_we: got=%b exp=0", ram_we); end
    n_checks++; if (cpu_wait !== 1'b1) begin n_fail++; $display("FAIL wr_ph2_wait: got=%b exp=1", cpu_wait); end
    tick();
    n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL wr_ph3_we: got=%b exp=1", ram_we); end
    n_checks++; if (ram_addr !== 13'h0123) begin n_fail++; $display("FAIL wr_ph3_addr: got=%h exp=0123", ram_addr); end
    n_checks++; if (ram_wdata !== 8'hA5) begin n_fail++; $display("FAIL wr_ph3_wdata: got=%h exp=a5", ram_wdata); end
    n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ph3_ack: got=%b exp=0", cpu_ack); end
    tick();
    n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ph4_ack: got=%b exp=1", cpu_ack); end
    n_checks++; if (cpu_wait !== 1'b0) begin n_fail++; $display("FAIL wr_ph4_wait: got=%b exp=0", cpu_wait); end
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL wr_ph4_we: got=%b exp=0", ram_we); end
    cpu_req = 1'b0;
    tick();
    n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ph5_ack: got=%b exp=0", cpu_ack); end
    n_checks++; if (mem[13'h0123] !== 8'hA5) begin n_fail++; $display("FAIL wr_mem: got=%h exp=a5", mem[13'h0123]); end
  endtask

  task automatic test_read_blocked();
    vid_addr = 13'h0555;
    cpu_write(13'h1ABC, 8'h3C);
    wait_phase(4'd10);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1ABC;
    #1;
    n_checks++; if (cpu_wait !== 1'b1) begin n_fail++; $display("FAIL rd_ph10_wait: got=%b exp=1", cpu_wait); end
    for (int p = 11; p <= 14; p++) begin
      tick();
      n_checks++; if (ram_we !== 1'b0 || ram_addr !== 13'h0555) begin n_fail++;
        $display("FAIL rd_win_ph%0d: we=%b addr=%h exp we=0 addr=0555", p, ram_we, ram_addr); end
      n_checks++; if (cpu_wait !== 1'b1 || cpu_ack !== 1'b0) begin n_fail++;
        $display("FAIL rd_win_hs_ph%0d: wait=%b ack=%b exp 1/0", p, cpu_wait, cpu_ack); end
      if (p == 12) begin
        n_checks++; if (vid_rdata !== pat(13'h0555)) begin n_fail++;
          $display("FAIL rd_vid_rdata: got=%h exp=%h", vid_rdata, pat(13'h0555)); end
      end
    end
    tick();
    n_checks++; if (ram_addr !== 13'h1ABC || ram_we !== 1'b0) begin n_fail++;
      $display("FAIL rd_issue_ph15: addr=%h we=%b exp 1abc/0", ram_addr, ram_we); end
    n_checks++; if (cpu_wait !== 1'b1) begin n_fail++; $display("FAIL rd_ph15_wait: got=%b exp=1", cpu_wait); end
    tick();
    n_checks++; if (cpu_wait !== 1'b1 || cpu_ack !== 1'b0) begin n_fail++;
      $display("FAIL rd_ph0: wait=%b ack=%b exp 1/0", cpu_wait, cpu_ack); end
    tick();
    n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rd_ph1_ack: got=%b exp=1", cpu_ack); end
    n_checks++; if (cpu_rdata !== 8'h3C) begin n_fail++; $display("FAIL rd_ph1_rdata: got=%h exp=3c", cpu_rdata); end
    n_checks++; if (cpu_wait !== 1'b0) begin n_fail++; $display("FAIL rd_ph1_wait: got=%b exp=0", cpu_wait); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_write_storm();
    int k;
    k = 0;
    vid_addr = 13'h1800;
    wait_phase(4'd0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0200; cpu_wdata = 8'h00;
    for (int c = 0; c < 48; c++) begin
      tick();
      if (cpu_ack) begin
        k++;
        cpu_addr = 13'h0200 + 13'(k);
        cpu_wdata = 8'(k);
      end
      if (vid_phase >= 4'd11 && vid_phase <= 4'd14) begin
        n_checks++; if (ram_we !== 1'b0 || ram_addr !== 13'h1800) begin n_fail++;
          $display("FAIL storm_win_ph%0d: we=%b addr=%h exp 0/1800", vid_phase, ram_we, ram_addr); end
      end
      if (vid_phase == 4'd12 || vid_phase == 4'd14) begin
        n_checks++; if (vid_rdata !== pat(13'h1800)) begin n_fail++;
          $display("FAIL storm_vid_rdata_ph%0d: got=%h exp=%h", vid_phase, vid_rdata, pat(13'h1800)); end
      end
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    n_checks++; if (k < 4) begin n_fail++; $display("FAIL storm_acks: got=%0d exp>=4", k); end
    n_checks++; if (mem[13'h0200] !== 8'h00) begin n_fail++; $display("FAIL storm_mem0: got=%h exp=00", mem[13'h0200]); end
    n_checks++; if (mem[13'h0201] !== 8'h01) begin n_fail++; $display("FAIL storm_mem1: got=%h exp=01", mem[13'h0201]); end
  endtask

  task automatic test_back_to_back();
    int acks, doubles, stage;
    logic prev_ack, raise;
    acks = 0; doubles = 0; stage = 0; prev_ack = 1'b0; raise = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0000;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (raise) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0001; cpu_wdata = 8'h77;
        raise = 1'b0;
      end
      if (cpu_ack) begin
        acks++;
        if (prev_ack) doubles++;
        cpu_req = 1'b0;
        if (stage == 0) begin
          n_checks++; if (cpu_rdata !== 8'h5A) begin n_fail++;
            $display("FAIL b2b_rdata: got=%h exp=5a", cpu_rdata); end
          n_checks++; if (mem[13'h0001] !== pat(1)) begin n_fail++;
            $display("FAIL b2b_order: mem1=%h exp=%h before write", mem[13'h0001], pat(1)); end
          raise = 1'b1;
        end
        stage++;
      end
      prev_ack = cpu_ack;
    end
    n_checks++; if (acks !== 2) begin n_fail++; $display("FAIL b2b_ack_count: got=%0d exp=2", acks); end
    n_checks++; if (doubles !== 0) begin n_fail++; $display("FAIL b2b_ack_width: got=%0d exp=0", doubles); end
    n_checks++; if (mem[13'h0001] !== 8'h77) begin n_fail++; $display("FAIL b2b_mem: got=%h exp=77", mem[13'h0001]); end
    n_checks++; if (wr1_cnt !== 1) begin n_fail++; $display("FAIL b2b_wr_count: got=%0d exp=1", wr1_cnt); end
  endtask

  task automatic test_reset_mid_read();
    wait_phase(4'd5);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1ABC;
    tick();
    tick();
    nreset = 1'b0;
    #1;
    n_checks++; if (cpu_ack !== 1'b0 || ram_we !== 1'b0) begin n_fail++;
      $display("FAIL rst_mid_outputs: ack=%b we=%b exp 0/0", cpu_ack, ram_we); end
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_mid_rdata: got=%h exp=00", cpu_rdata); end
    cpu_req = 1'b0;
    #1;
    n_checks++; if (cpu_wait !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wait: got=%b exp=0", cpu_wait); end
    tick();
    tick();
    nreset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (cpu_ack !== 1'b0 || ram_we !== 1'b0 || ram_addr !== vid_addr) begin n_fail++;
        $display("FAIL rst_post_idle_%0d: ack=%b we=%b addr=%h exp 0/0/%h", i, cpu_ack, ram_we,
                 ram_addr, vid_addr); end
    end
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_post_rdata: got=%h exp=00", cpu_rdata); end
  endtask

  task automatic test_addr_change_pending();
    vid_addr = 13'h0444;
    wait_phase(4'd10);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 8'h99;
    tick();
    cpu_addr = 13'h0020; cpu_wdata = 8'h11;
    for (int p = 12; p <= 14; p++) begin
      tick();
      n_checks++; if (ram_we !== 1'b0 || ram_addr !== 13'h0444) begin n_fail++;
        $display("FAIL chg_win_ph%0d: we=%b addr=%h exp 0/0444", p, ram_we, ram_addr); end
    end
    tick();
    n_checks++; if (ram_addr !== 13'h0010 || ram_we !== 1'b1 || ram_wdata !== 8'h99) begin n_fail++;
      $display("FAIL chg_issue: addr=%h we=%b wdata=%h exp 0010/1/99", ram_addr, ram_we, ram_wdata); end
    tick();
    n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL chg_ack: got=%b exp=1", cpu_ack); end
    cpu_req = 1'b0;
    tick();
    n_checks++; if (mem[13'h0010] !== 8'h99) begin n_fail++; $display("FAIL chg_mem10: got=%h exp=99", mem[13'h0010]); end
    n_checks++; if (mem[13'h0020] !== pat(13'h0020)) begin n_fail++;
      $display("FAIL chg_mem20: got=%h exp=%h", mem[13'h0020], pat(13'h0020)); end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = pat(i);
    test_reset();
    test_write_best_case();
    test_read_blocked();
    test_write_storm();
    test_back_to_back();
    test_reset_mid_read();
    test_addr_change_pending();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Owns the single-port 8 KB video RAM (13-bit address, 8-bit data, registered address, read data valid the cycle after the address is presented).
- Shares the RAM between the VGA video fetch stage and the CPU bus. Feeds the video stage its vram_data.
- Video has fixed, guaranteed slots in every 16-clock character cell. The CPU gets all other phases through a req/ack handshake, with a wait signal for contention.

Parameters:
- ADDR_W, 13, RAM address width.
- VID_FIRST, 11, first character-phase value reserved for video.
- VID_LAST, 14, last character-phase value reserved for video; VID_FIRST..VID_LAST inclusive, no wrap.

Ports:
- clk_pix  in  1  pixel clock; all logic on the rising edge.
- nreset  in  1  asynchronous active-low reset.
- vid_phase  in  4  low 4 bits of the video horizontal counter (character phase).
- vid_addr  in  ADDR_W  video fetch address (registered in the video stage).
- vid_rdata  out  8  read data to the video stage; equals ram_q, combinational.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
- cpu_addr  in  ADDR_W  CPU address; qualified by cpu_req.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  registered read data; valid in the cpu_ack cycle and held until the next read completes.
- cpu_ack  out  1  one-cycle completion pulse, registered.
- cpu_wait  out  1  high while a CPU request is outstanding (Z80 WAIT, active-high here).
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_q  in  8  RAM read data.

Behaviour:
- Reset (nreset low, asynchronous) values:
  - FSM = IDLE; cpu_ack = 0; cpu_rdata = 0; ram_we = 0; latched CPU address/data/we = 0.
  - cpu_wait = 0 once cpu_req is low.
  - Reset mid-transfer aborts it: no ack, no further RAM write.
- Video window: vid_phase in VID_FIRST..VID_LAST.
  - ram_addr = vid_addr and ram_we = 0, unconditionally.
  - The CPU never drives the RAM in these phases.
- Outside the window, ram_addr = vid_addr except in an ISSUE cycle.
- FSM states: IDLE, PEND, RD_DATA, ACK.
  - IDLE: if cpu_req is sampled high at the edge, latch cpu_we, cpu_addr and cpu_wdata, then go to PEND.
  - PEND: evaluated each cycle.
    - If vid_phase is outside the video window, this cycle is the ISSUE cycle: ram_addr = latched address; ram_we = latched we; ram_wdata = latched data.
    - After an ISSUE cycle, next state is ACK for a write and RD_DATA for a read.
    - Otherwise (video window) stay in PEND.
  - RD_DATA: capture ram_q into cpu_rdata at the end of the cycle; go to ACK. The phase in this cycle is irrelevant, since the captured address was registered on the previous edge.
  - ACK: cpu_ack = 1 for exactly this cycle; return to IDLE.
    - The requester drops cpu_req in the ACK cycle.
    - cpu_req high in the following IDLE cycle is a new request.
- Latency, with request sampled at end of cycle t:
  - Write: ISSUE at t+1 (best case); ack at t+2.
  - Read: ISSUE at t+1; capture at t+2; ack at t+3.
  - Worst case (PEND entered at phase VID_FIRST) adds 4 cycles.
- cpu_wait = cpu_req & (state != ACK). It falls in the ack cycle.
- Video timing guarantee: a video address registered at the end of phase 10/12 is presented through phases 11–14. ram_q returns its data in phases 12/14. The CPU cannot disturb this; vid_rdata in phases 12 and 14 always reflects vid_addr.
- vid_phase wraps 15→0 freely; phases 15 and 0..10 are CPU-eligible.
- cpu_req dropped before ack is illegal: the latched access still completes and acks.
- Address/data changes while pending are ignored (latched copy used).

Test Plan:
1. Reset, then hold cpu_req=1, we=1, addr=0x0123, wdata=0xA5, sampled at phase 2 -> ram_we=1 with ram_addr=0x0123 and ram_wdata=0xA5 in phase 3 only; cpu_ack pulse in phase 4; cpu_wait low in phase 4.
2. Write 0x3C to 0x1ABC, then read 0x1ABC with request sampled at phase 10 -> issue at phase 11 is blocked; issue at phase 15 with ram_we=0; cpu_rdata=0x3C with cpu_ack at phase 1; cpu_wait high for phases 11–0.
3. Continuous CPU write storm (new request each cycle after ack) while vid_addr=0x1800 at phases 11–14 -> ram_we=0 and ram_addr=0x1800 in every phase 11–14; vid_rdata in phases 12 and 14 matches RAM model contents.
4. Back-to-back read at 0x0000 then write at 0x0001, request raised in the cycle after the first ack -> both complete in order; exactly two one-cycle ack pulses; RAM[0x0001] updated once.
5. Read request sampled at phase 5, nreset pulsed low during RD_DATA -> outputs reset immediately; no cpu_ack; FSM IDLE; cpu_rdata=0 after release.
6. cpu_addr changed from 0x0010 to 0x0020 while in PEND during the video window -> RAM access uses 0x0010.
